// File: rtl/dmem_lsu_pkg.sv
// Shared types and helpers for the data-memory load/store unit.
// Holds funct3 encodings, the FSM state type and the store lane builder.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0]  byte_sel;
        logic [31:0] wdata;
    } wr_lanes_t;

    // Stores only look at funct3[1:0]; illegal encodings are filtered before use.
    function automatic wr_lanes_t store_lanes(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] d);
        wr_lanes_t r;
        case (f3[1:0])
            2'b00: begin
                r.byte_sel = 4'b0001 << off;
                r.wdata    = {4{d[7:0]}};
            end
            2'b01: begin
                r.byte_sel = off[1] ? 4'b1100 : 4'b0011;
                r.wdata    = {2{d[15:0]}};
            end
            default: begin
                r.byte_sel = 4'b1111;
                r.wdata    = d;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response handshake and BRAM port bundle for dmem_lsu.
// slave is the LSU side; master is the pipeline/BRAM environment side.
interface dmem_lsu_if #(
    parameter int ADDR_W = 11
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_error;
    logic              mem_ren;
    logic              mem_wen;
    logic [3:0]        mem_byte_sel;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error,
               mem_ren, mem_wen, mem_byte_sel, mem_address, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error,
               mem_ren, mem_wen, mem_byte_sel, mem_address, mem_wdata
    );
endinterface

// File: rtl/dmem_lsu_load_extract.sv
// Selects the addressed byte/halfword/word from a BRAM word and extends it.
module load_extract
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    logic [31:0] lane;

    always_comb begin
        lane = rdata >> {offset, 3'b000};
        data = lane;
        case (funct3)
            F3_B:    data = {{24{lane[7]}}, lane[7:0]};
            F3_H:    data = {{16{lane[15]}}, lane[15:0]};
            F3_BU:   data = {24'd0, lane[7:0]};
            F3_HU:   data = {16'd0, lane[15:0]};
            default: data = lane;
        endcase
    end
endmodule

// File: rtl/dmem_lsu.sv
// RV32 load/store unit in front of a word-organised BRAM with fixed read latency.
// One request in flight; memory port is only driven during the accept cycle.
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W       = 11,
    parameter int READ_LATENCY = 1
) (
    input logic       clk,
    input logic       reset,
    dmem_lsu_if.slave bus
);
    state_t      state, state_nxt;
    logic [1:0]  cnt;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic [31:0] rdata_q;
    logic        error_q;
    logic        accept, misalign, illegal, err, cnt_done;
    logic [31:0] ext_data;
    wr_lanes_t   lanes;
    logic        unused_addr_hi;

    // Upper address bits simply alias onto the BRAM.
    assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

    assign bus.req_ready = (state == S_IDLE) && reset;
    assign accept        = bus.req_valid && bus.req_ready;
    assign cnt_done      = (cnt == 2'(READ_LATENCY - 1));
    assign lanes         = store_lanes(bus.req_funct3, bus.req_addr[1:0], bus.req_wdata);

    always_comb begin
        misalign = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                   ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
        if (bus.req_we)
            illegal = (bus.req_funct3 > F3_W);
        else
            illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                      (bus.req_funct3 == 3'b111);
    end
    assign err = misalign || illegal;

    always_comb begin
        bus.mem_ren      = 1'b0;
        bus.mem_wen      = 1'b0;
        bus.mem_byte_sel = 4'b0000;
        bus.mem_address  = '0;
        bus.mem_wdata    = 32'd0;
        if (accept && !err) begin
            bus.mem_address = bus.req_addr[ADDR_W+1:2];
            if (bus.req_we) begin
                bus.mem_wen      = 1'b1;
                bus.mem_byte_sel = lanes.byte_sel;
                bus.mem_wdata    = lanes.wdata;
            end else begin
                bus.mem_ren = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = (err || bus.req_we) ? S_RESP : S_WAIT;
            S_WAIT:  if (cnt_done) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    load_extract u_extract (
        .rdata  (bus.mem_rdata),
        .offset (off_q),
        .funct3 (f3_q),
        .data   (ext_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= 2'd0;
            off_q   <= 2'd0;
            f3_q    <= 3'd0;
            rdata_q <= 32'd0;
            error_q <= 1'b0;
        end else if (accept) begin
            cnt   <= 2'd0;
            off_q <= bus.req_addr[1:0];
            f3_q  <= bus.req_funct3;
            if (err || bus.req_we) begin
                rdata_q <= 32'd0;
                error_q <= err;
            end
        end else if (state == S_WAIT) begin
            cnt <= cnt + 2'd1;
            if (cnt_done) begin
                rdata_q <= ext_data;
                error_q <= 1'b0;
            end
        end
    end

    assign bus.rsp_valid = (state == S_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_error = error_q;
endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench: two LSUs (read latency 1 and 2), each with its own word BRAM model.
module tb_dmem_lsu;
    import lsu_pkg::*;

    localparam int AW = 11;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [1:0]          req_valid, req_we;
    logic [1:0][2:0]     req_funct3;
    logic [1:0][31:0]    req_addr, req_wdata;
    logic [1:0]          req_ready, rsp_valid, rsp_error, mem_ren, mem_wen;
    logic [1:0][31:0]    rsp_rdata, mem_wdata;
    logic [1:0][3:0]     mem_byte_sel;
    logic [1:0][AW-1:0]  mem_address;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int L = g + 1;
        dmem_lsu_if #(.ADDR_W(AW)) bus ();
        logic [31:0] mem [0:(1<<AW)-1];
        logic [31:0] rd_pipe [0:1];

        assign bus.req_valid  = req_valid[g];
        assign bus.req_we     = req_we[g];
        assign bus.req_funct3 = req_funct3[g];
        assign bus.req_addr   = req_addr[g];
        assign bus.req_wdata  = req_wdata[g];
        assign req_ready[g]    = bus.req_ready;
        assign rsp_valid[g]    = bus.rsp_valid;
        assign rsp_rdata[g]    = bus.rsp_rdata;
        assign rsp_error[g]    = bus.rsp_error;
        assign mem_ren[g]      = bus.mem_ren;
        assign mem_wen[g]      = bus.mem_wen;
        assign mem_byte_sel[g] = bus.mem_byte_sel;
        assign mem_address[g]  = bus.mem_address;
        assign mem_wdata[g]    = bus.mem_wdata;

        dmem_lsu #(.ADDR_W(AW), .READ_LATENCY(L)) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus.slave)
        );

        // BRAM returns junk whenever no read was issued, exposing off-by-one captures.
        always @(posedge clk) begin
            if (bus.mem_wen)
                for (int b = 0; b < 4; b++)
                    if (bus.mem_byte_sel[b]) mem[bus.mem_address][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            rd_pipe[0] <= bus.mem_ren ? mem[bus.mem_address] : 32'h5A5A_0BAD;
            rd_pipe[1] <= rd_pipe[0];
        end
        assign bus.mem_rdata = (L == 1) ? rd_pipe[0] : rd_pipe[1];
    end

    task automatic drive(input int d, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        req_valid[d] = 1'b1; req_we[d] = we; req_funct3[d] = f3;
        req_addr[d] = a; req_wdata[d] = wd;
        #1;
    endtask

    task automatic wait_rsp(input int d, output int lat);
        lat = 0;
        do begin
            @(negedge clk); req_valid[d] = 1'b0; #1; lat++;
        end while (!rsp_valid[d] && lat < 10);
        if (!rsp_valid[d]) lat = 99;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = '1; req_we = '1; req_funct3 = {F3_W, F3_W};
        req_addr = {32'h10, 32'h10}; req_wdata = '1;
        #1 reset = 1'b0;
        #2;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({req_ready[d], rsp_valid[d], rsp_error[d], rsp_rdata[d]} !== '0) begin
                errors++; $display("FAIL reset_outs d%0d got rdy=%0b v=%0b e=%0b rd=%h want all 0",
                                   d, req_ready[d], rsp_valid[d], rsp_error[d], rsp_rdata[d]);
            end
            checks++;
            if ({mem_ren[d], mem_wen[d], mem_byte_sel[d], mem_address[d], mem_wdata[d]} !== '0) begin
                errors++; $display("FAIL reset_mem d%0d got wen=%0b sel=%b want 0", d, mem_wen[d], mem_byte_sel[d]);
            end
        end
        @(negedge clk); @(negedge clk);
        req_valid = '0; reset = 1'b1; #1;
        checks++;
        if (req_ready !== 2'b11) begin
            errors++; $display("FAIL reset_release_ready got %b want 11", req_ready);
        end
    endtask

    task automatic test_store_word(input int d);
        int lat;
        drive(d, 1'b1, F3_W, 32'h0000_0010, 32'hDEAD_BEEF);
        checks++;
        if ({req_ready[d], mem_wen[d], mem_ren[d], mem_byte_sel[d], mem_address[d], mem_wdata[d]} !==
            {1'b1, 1'b1, 1'b0, 4'b1111, 11'd4, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL sw_mem d%0d got wen=%0b ren=%0b sel=%b adr=%0d wd=%h want 1 0 1111 4 deadbeef",
                               d, mem_wen[d], mem_ren[d], mem_byte_sel[d], mem_address[d], mem_wdata[d]);
        end
        wait_rsp(d, lat);
        checks++;
        if (lat !== 1 || rsp_error[d] !== 1'b0 || rsp_rdata[d] !== 32'd0) begin
            errors++; $display("FAIL sw_rsp d%0d got lat=%0d err=%0b rd=%h want 1 0 0", d, lat, rsp_error[d], rsp_rdata[d]);
        end
        checks++;
        if (req_ready[d] !== 1'b0) begin
            errors++; $display("FAIL sw_ready_in_resp d%0d got %0b want 0", d, req_ready[d]);
        end
    endtask

    task automatic test_store_byte_load(input int d);
        int lat;
        drive(d, 1'b1, F3_B, 32'h0000_0013, 32'h0000_00A5);
        checks++;
        if ({mem_wen[d], mem_byte_sel[d], mem_address[d], mem_wdata[d]} !== {1'b1, 4'b1000, 11'd4, 32'hA5A5_A5A5}) begin
            errors++; $display("FAIL sb_mem d%0d got sel=%b adr=%0d wd=%h want 1000 4 a5a5a5a5",
                               d, mem_byte_sel[d], mem_address[d], mem_wdata[d]);
        end
        wait_rsp(d, lat);
        checks++;
        if (lat !== 1) begin
            errors++; $display("FAIL sb_lat d%0d got %0d want 1", d, lat);
        end
        drive(d, 1'b0, F3_W, 32'h0000_0010, 32'h0);
        checks++;
        if ({mem_ren[d], mem_wen[d], mem_byte_sel[d], mem_address[d]} !== {1'b1, 1'b0, 4'b0000, 11'd4}) begin
            errors++; $display("FAIL lw_mem d%0d got ren=%0b wen=%0b sel=%b adr=%0d want 1 0 0000 4",
                               d, mem_ren[d], mem_wen[d], mem_byte_sel[d], mem_address[d]);
        end
        wait_rsp(d, lat);
        checks++;
        if (lat !== d + 2 || rsp_rdata[d] !== 32'hA5AD_BEEF || rsp_error[d] !== 1'b0) begin
            errors++; $display("FAIL lw_rsp d%0d got lat=%0d rd=%h err=%0b want %0d a5adbeef 0",
                               d, lat, rsp_rdata[d], rsp_error[d], d + 2);
        end
    endtask

    task automatic test_load_extend(input int d);
        int lat;
        logic [2:0]  f3s  [5];
        logic [31:0] adrs [5];
        logic [31:0] exps [5];
        f3s  = '{F3_B, F3_BU, F3_H, F3_HU, F3_W};
        adrs = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h2010};
        exps = '{32'hFFFF_FFA5, 32'h0000_00A5, 32'hFFFF_A5AD, 32'h0000_BEEF, 32'hA5AD_BEEF};
        for (int i = 0; i < 5; i++) begin
            drive(d, 1'b0, f3s[i], adrs[i], 32'h0);
            checks++;
            if (mem_ren[d] !== 1'b1 || mem_address[d] !== 11'd4) begin
                errors++; $display("FAIL ld%0d_mem d%0d got ren=%0b adr=%0d want 1 4", i, d, mem_ren[d], mem_address[d]);
            end
            wait_rsp(d, lat);
            checks++;
            if (lat !== d + 2 || rsp_rdata[d] !== exps[i]) begin
                errors++; $display("FAIL ld%0d_rsp d%0d got lat=%0d rd=%h want %0d %h", i, d, lat, rsp_rdata[d], d + 2, exps[i]);
            end
        end
    endtask

    task automatic test_reset_mid_load(input int d);
        int lat;
        int seen = 0;
        drive(d, 1'b0, F3_W, 32'h10, 32'h0);
        @(negedge clk); req_valid[d] = 1'b0; #1;
        checks++;
        if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b0) begin
            errors++; $display("FAIL mid_wait d%0d got v=%0b rdy=%0b want 0 0", d, rsp_valid[d], req_ready[d]);
        end
        #1 reset = 1'b0; #1;
        checks++;
        if ({rsp_valid[d], rsp_error[d], rsp_rdata[d], req_ready[d], mem_ren[d]} !== '0) begin
            errors++; $display("FAIL mid_reset d%0d got v=%0b rd=%h rdy=%0b want 0", d, rsp_valid[d], rsp_rdata[d], req_ready[d]);
        end
        @(negedge clk); @(negedge clk); reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1 if (rsp_valid[d]) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL mid_no_rsp d%0d got %0d pulses want 0", d, seen);
        end
        drive(d, 1'b0, F3_W, 32'h10, 32'h0);
        wait_rsp(d, lat);
        checks++;
        if (lat !== d + 2 || rsp_rdata[d] !== 32'hA5AD_BEEF) begin
            errors++; $display("FAIL mid_reload d%0d got lat=%0d rd=%h want %0d a5adbeef", d, lat, rsp_rdata[d], d + 2);
        end
    endtask

    task automatic test_errors(input int d);
        int lat;
        logic        wes  [3];
        logic [2:0]  f3s  [3];
        logic [31:0] adrs [3];
        wes  = '{1'b0, 1'b1, 1'b0};
        f3s  = '{F3_W, F3_H, 3'b011};
        adrs = '{32'h11, 32'h01, 32'h10};
        for (int i = 0; i < 3; i++) begin
            drive(d, wes[i], f3s[i], adrs[i], 32'hFFFF_FFFF);
            checks++;
            if ({mem_ren[d], mem_wen[d], mem_byte_sel[d], mem_address[d], mem_wdata[d]} !== '0) begin
                errors++; $display("FAIL err%0d_mem d%0d got ren=%0b wen=%0b sel=%b want 0", i, d, mem_ren[d], mem_wen[d], mem_byte_sel[d]);
            end
            wait_rsp(d, lat);
            checks++;
            if (lat !== 1 || rsp_error[d] !== 1'b1 || rsp_rdata[d] !== 32'd0) begin
                errors++; $display("FAIL err%0d_rsp d%0d got lat=%0d err=%0b rd=%h want 1 1 0", i, d, lat, rsp_error[d], rsp_rdata[d]);
            end
        end
    endtask

    task automatic test_back_to_back(input int d);
        logic        wes  [4];
        logic [2:0]  f3s  [4];
        logic [31:0] adrs [4];
        logic [31:0] wds  [4];
        int acc [4];
        int idx = 0, cyc = 0, both = 0, rdy_bad = 0;
        logic [31:0] ld_data = 32'h0;
        wes  = '{1'b1, 1'b1, 1'b0, 1'b1};
        f3s  = '{F3_W, F3_B, F3_W, F3_H};
        adrs = '{32'h20, 32'h21, 32'h20, 32'h03};
        wds  = '{32'h1122_3344, 32'h0000_0055, 32'h0, 32'h0};
        acc  = '{0, 0, 0, 0};
        @(negedge clk);
        req_valid[d] = 1'b1; req_we[d] = wes[0]; req_funct3[d] = f3s[0];
        req_addr[d] = adrs[0]; req_wdata[d] = wds[0];
        while (idx < 4 && cyc < 60) begin
            #1;
            if (mem_ren[d] && mem_wen[d]) both++;
            if (idx > 0 && cyc == acc[idx-1] + 1 && req_ready[d]) rdy_bad++;
            if (rsp_valid[d] && idx == 3) ld_data = rsp_rdata[d];
            if (req_ready[d]) begin acc[idx] = cyc; idx++; end
            @(negedge clk); cyc++;
            if (idx < 4) begin
                req_we[d] = wes[idx]; req_funct3[d] = f3s[idx];
                req_addr[d] = adrs[idx]; req_wdata[d] = wds[idx];
            end
        end
        req_valid[d] = 1'b0; #1;
        checks++;
        if (acc[1] - acc[0] !== 2 || acc[2] - acc[1] !== 2 || acc[3] - acc[2] !== d + 3) begin
            errors++; $display("FAIL b2b_spacing d%0d got %0d %0d %0d want 2 2 %0d",
                               d, acc[1] - acc[0], acc[2] - acc[1], acc[3] - acc[2], d + 3);
        end
        checks++;
        if (both !== 0 || rdy_bad !== 0) begin
            errors++; $display("FAIL b2b_excl d%0d got both=%0d rdy_after_acc=%0d want 0 0", d, both, rdy_bad);
        end
        checks++;
        if (ld_data !== 32'h1122_5544) begin
            errors++; $display("FAIL b2b_load d%0d got %h want 11225544", d, ld_data);
        end
        checks++;
        if (rsp_valid[d] !== 1'b1 || rsp_error[d] !== 1'b1) begin
            errors++; $display("FAIL b2b_err d%0d got v=%0b e=%0b want 1 1", d, rsp_valid[d], rsp_error[d]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        for (int d = 0; d < 2; d++) begin
            test_store_word(d);
            test_store_byte_load(d);
            test_load_extend(d);
            test_reset_mid_load(d);
            test_errors(d);
            test_back_to_back(d);
        end
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit sitting directly upstream of the word-organised data BRAM. Accepts one byte-addressed RV32 load or store from the execute/memory stage per handshake. Drives the BRAM port with these signals:
- word address;
- per-byte write-enable vector;
- lane-replicated write data;
- read-enable.

For loads, it waits out the BRAM read latency, then extracts and sign/zero-extends the addressed byte, halfword or word. Misaligned and illegal requests are rejected without touching memory.

## Interface
- ADDR_W, 11, BRAM word-address width (depth 2^ADDR_W words).
- READ_LATENCY, 1, BRAM cycles from read address to valid mem_rdata; legal values 1 or 2.

- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; 0 = in reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; a request transfers when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_rdata  out  32  extended load data; 0 for stores/errors.
- rsp_error  out  1  request was misaligned or had illegal funct3.
- mem_ren  out  1  BRAM read enable.
- mem_wen  out  1  BRAM write enable; never high together with mem_ren.
- mem_byte_sel  out  4  per-lane write enable; bit i = bits [8i+7:8i].
- mem_address  out  ADDR_W  word address = req_addr[ADDR_W+1:2].
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  BRAM read data.

## Operation
- States: IDLE, WAIT, RESP. req_ready = (state==IDLE) && reset.
- Accept in IDLE → classify:
  - error: no memory access, goto RESP;
  - store: memory write this cycle, goto RESP;
  - load: mem_ren this cycle, goto WAIT.
- Memory outputs are combinational from the request during the accept cycle only. At all other times, all mem_* outputs are 0.
- mem_address ignores req_addr[31:ADDR_W+2] (aliases/wraps, no error).
- Misaligned:
  - halfword with addr[0]=1;
  - word with addr[1:0]≠0.
- Illegal funct3:
  - loads: 011, 110, 111;
  - stores: any value other than 000/001/010.
- Byte select:
  - SB = 1<<addr[1:0];
  - SH = addr[1] ? 1100 : 0011;
  - SW = 1111.
- Write data:
  - SB replicates wdata[7:0] ×4;
  - SH replicates wdata[15:0] ×2;
  - SW passes through.
- Load extraction uses addr[1:0] and funct3 latched at accept. Lane = mem_rdata >> 8·offset. LB/LH sign-extend; LBU/LHU zero-extend.
- WAIT counts READ_LATENCY cycles, then captures the extracted data into rsp_rdata and goes to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE.

## Timing
- Accept at cycle N.
  - Store or error: rsp_valid at N+1.
  - Load: rsp_valid at N+READ_LATENCY+1.
- req_ready is low from N+1 through the rsp_valid cycle. The next accept is possible at rsp_valid cycle +1. Store throughput is 1 per 2 cycles.
- rsp_rdata/rsp_error are held until the next response. They are valid only while rsp_valid=1.
- Reset values: state IDLE, rsp_valid 0, rsp_rdata 0, rsp_error 0, counter 0. req_ready is 0 while reset is low and 1 after reset release.
- Reset mid-operation: any in-flight load is discarded immediately and no response is produced. BRAM data returning afterwards is ignored.

## Structure
- Shared package lsu_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - state encoding;
  - the lane-replication/byte-select helper function.
- One sub-module: load_extract, combinational (mem_rdata, offset[1:0], funct3) → 32-bit extended data.

## Test plan
- Bench uses a word BRAM model with READ_LATENCY cycles of latency, run at both 1 and 2.
- SW addr 0x0000_0010, data 0xDEADBEEF:
  - accept cycle: mem_wen=1, mem_address=4, mem_byte_sel=1111, mem_wdata=0xDEADBEEF;
  - rsp_valid at N+1, rsp_error=0.
- SB addr 0x13, data 0x000000A5 → mem_byte_sel=1000, mem_wdata=0xA5A5A5A5. Then LW 0x10 → rsp_rdata=0xA5ADBEEF at N+L+1.
- Word at 0x10 = 0xA5ADBEEF:
  - LB 0x13 → 0xFFFFFFA5;
  - LBU 0x13 → 0x000000A5;
  - LH 0x12 → 0xFFFFA5AD;
  - LHU 0x10 → 0x0000BEEF.
- Misaligned/illegal requests produce no memory activity and rsp_valid at N+1 with rsp_error=1, rsp_rdata=0:
  - LW 0x11;
  - SH 0x01;
  - load funct3=011.
- Back-to-back requests with req_valid held high: req_ready deasserts after each accept. mem_ren and mem_wen are never both 1. Accepts are spaced exactly as specified in Timing.
- Assert reset during WAIT of an LW:
  - all outputs go to reset values asynchronously;
  - no rsp_valid appears after release;
  - the next LW returns correct data.
